// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and flag bit positions for alu_seq_acc
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int F_C = 3;
    localparam int F_V = 2;
    localparam int F_N = 1;
    localparam int F_Z = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add unsigned multiplier, one bit of b per enabled cycle
// Only instantiated when ALU_MUL_EN is defined.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (ena) begin
            if (start) begin
                r_mcand  <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
            end else if (r_busy) begin
                if (r_mplier[0]) begin
                    r_prod <= r_prod + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                // done stays high until the next start so the FSM can sample it late
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq_acc.sv
// rtl/alu_seq_acc.sv - sequential ALU with accumulator, {C,V,N,Z} flags and valid/ready handshakes
// Define ALU_MUL_EN for the iterative multiplier; otherwise op 7 returns an illegal-op marker.
module alu_seq_acc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags
);

    import alu_seq_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;

    logic             w_accept;
    logic             w_res_hs;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH:0]   w_shr;
    logic [SHW-1:0]   w_sh;

    assign in_ready  = rst_n && ena && (r_state == S_IDLE);
    assign out_valid = ena && (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_res_hs  = out_valid && out_ready;
    assign w_a_sel   = use_acc ? r_acc : a;
    assign y         = r_y;
    assign flags     = r_flags;

    // One guard bit on each shift catches the last bit shifted out (zero for amount 0)
    assign w_sh  = r_b[SHW-1:0];
    assign w_shl = {1'b0, r_a} << w_sh;
    assign w_shr = {r_a, 1'b0} >> w_sh;

`ifdef ALU_MUL_EN
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [3:0]         w_mflags;

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (w_accept && (op == OP_MUL)),
        .a       (w_a_sel),
        .b       (b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_prod)
    );

    always_comb begin
        w_mflags      = '0;
        w_mflags[F_C] = |w_prod[2*WIDTH-1:WIDTH];
        w_mflags[F_N] = w_prod[WIDTH-1];
        w_mflags[F_Z] = (w_prod[WIDTH-1:0] == '0);
    end
`endif

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_sum = '0;
        case (r_op)
            OP_ADD: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sum = {1'b0, r_a} - {1'b0, r_b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[WIDTH:1];
                w_c   = w_shr[0];
            end
            OP_MUL: begin
`ifndef ALU_MUL_EN
                w_c = 1'b1;
                w_v = 1'b1;
`endif
            end
        endcase
        w_flags      = '0;
        w_flags[F_C] = w_c;
        w_flags[F_V] = w_v;
        w_flags[F_N] = w_res[WIDTH-1];
        w_flags[F_Z] = (w_res == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_y     <= '0;
            r_flags <= '0;
        end else if (ena) begin
            if (acc_clr) begin
                r_acc <= '0;
            end else if (w_res_hs) begin
                r_acc <= r_y;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= op;
                        r_a  <= w_a_sel;
                        r_b  <= b;
`ifdef ALU_MUL_EN
                        r_state <= (op == OP_MUL) ? S_MUL : S_EXEC;
`else
                        r_state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    r_y     <= w_res;
                    r_flags <= w_flags;
                    r_state <= S_DONE;
                end
                S_MUL: begin
`ifdef ALU_MUL_EN
                    if (w_mul_done && !w_mul_busy) begin
                        r_y     <= w_prod[WIDTH-1:0];
                        r_flags <= w_mflags;
                        r_state <= S_DONE;
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_acc.sv
// tb/tb_alu_seq_acc.sv - directed and random checks of alu_seq_acc against an arithmetic reference
module tb_alu_seq_acc;

    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'd0;
    logic       use_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic [3:0] flags;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] acc = 8'd0;
    logic [7:0] last_y;
    logic [3:0] last_f;

    alu_seq_acc #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_acc   (use_acc),
        .acc_clr   (acc_clr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {C, V, N, Z, y} for an 8-bit datapath using integer arithmetic
    function automatic logic [11:0] model(input logic [2:0] opc, input logic [7:0] av, input logic [7:0] bv);
        int ai, bi, sa, sb, r, sh;
        bit c, v;
        logic [7:0] yy;
        ai = int'(av);
        bi = int'(bv);
        sa = (ai > 127) ? ai - 256 : ai;
        sb = (bi > 127) ? bi - 256 : bi;
        sh = bi % 8;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (opc)
            3'd0: begin r = ai + bi; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
            3'd1: begin r = ai - bi; c = (ai < bi); v = (sa - sb > 127) || (sa - sb < -128); end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: begin r = ai << sh; c = (sh != 0) && (((ai >> (8 - sh)) & 1) == 1); end
            3'd6: begin r = ai >> sh; c = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1); end
            default: begin
`ifdef ALU_MUL_EN
                r = ai * bi;
                c = (r > 255);
`else
                r = 0;
                c = 1'b1;
                v = 1'b1;
`endif
            end
        endcase
        yy = 8'(r & 255);
        return {c, v, yy[7], (yy == 8'd0), yy};
    endfunction

    task automatic run_op(input logic [2:0] opc, input logic [7:0] av, input logic [7:0] bv,
                          input bit ua, input bit clr_hs, input int hold, input int gap);
        logic [11:0] exp_r;
        logic [7:0]  a_eff;
        int          lat, exp_lat, guard, drop;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        a_eff = ua ? acc : av;
        exp_r = model(opc, a_eff, bv);
        exp_lat = 2 + gap;
`ifdef ALU_MUL_EN
        if (opc == 3'd7) exp_lat = 10 + gap;
`endif
        op = opc; a = av; b = bv; use_acc = ua; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); use_acc = 1'($urandom);
        lat = 1;
        if (gap > 0) begin
            drop = (exp_lat - gap > 3) ? 3 : 1;
            while (lat < drop) begin @(posedge clk); #1; lat++; end
            ena = 1'b0;
            repeat (gap) begin @(posedge clk); #1; lat++; end
            ena = 1'b1;
        end
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("y", 32'(y), 32'(exp_r[7:0]));
        check("flags", 32'(flags), 32'(exp_r[11:8]));
        last_y = y;
        last_f = flags;
        repeat (hold) begin
            @(posedge clk); #1;
            check("hold_y", 32'(y), 32'(exp_r[7:0]));
            check("hold_flags", 32'(flags), 32'(exp_r[11:8]));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        acc_clr = clr_hs;
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc_clr = 1'b0;
        acc = clr_hs ? 8'h00 : exp_r[7:0];
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op(OP_ADD, 8'hF0, 8'h20, 1'b0, 1'b0, 0, 0);
        check("add_lit_y", 32'(last_y), 32'h10);
        check("add_lit_f", 32'(last_f), 32'b1000);
        run_op(OP_SUB, 8'h80, 8'h01, 1'b0, 1'b0, 0, 0);
        check("sub1_lit_y", 32'(last_y), 32'h7F);
        check("sub1_lit_f", 32'(last_f), 32'b0100);
        run_op(OP_SUB, 8'h03, 8'h05, 1'b0, 1'b0, 0, 0);
        check("sub2_lit_y", 32'(last_y), 32'hFE);
        check("sub2_lit_f", 32'(last_f), 32'b1010);

        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        acc = 8'h00;
        run_op(OP_ADD, 8'hAA, 8'h05, 1'b1, 1'b0, 0, 0);
        check("acc1_lit", 32'(last_y), 32'h05);
        run_op(OP_ADD, 8'hAA, 8'h05, 1'b1, 1'b0, 0, 0);
        check("acc2_lit", 32'(last_y), 32'h0A);
        run_op(OP_ADD, 8'hAA, 8'h05, 1'b1, 1'b0, 0, 0);
        check("acc3_lit", 32'(last_y), 32'h0F);
        run_op(OP_ADD, 8'hAA, 8'h05, 1'b1, 1'b1, 0, 0);
        run_op(OP_ADD, 8'hAA, 8'h00, 1'b1, 1'b0, 0, 0);
        check("acc_clr_wins_y", 32'(last_y), 32'h00);
        check("acc_clr_wins_f", 32'(last_f), 32'b0001);

        run_op(OP_MUL, 8'h12, 8'h10, 1'b0, 1'b0, 0, 0);
`ifdef ALU_MUL_EN
        check("mul_lit_y", 32'(last_y), 32'h20);
        check("mul_lit_f", 32'(last_f), 32'b1000);
`else
        check("mul_lit_y", 32'(last_y), 32'h00);
        check("mul_lit_f", 32'(last_f), 32'b1101);
`endif

        run_op(OP_XOR, 8'h5A, 8'h3C, 1'b0, 1'b0, 5, 0);
        run_op(OP_MUL, 8'h9D, 8'h37, 1'b0, 1'b0, 0, 3);
        run_op(OP_SHL, 8'h81, 8'h01, 1'b0, 1'b0, 0, 0);
        check("shl_lit_y", 32'(last_y), 32'h02);
        check("shl_lit_f", 32'(last_f), 32'b1000);
        run_op(OP_SHR, 8'h81, 8'h00, 1'b0, 1'b0, 1, 0);
        check("shr0_lit_f", 32'(last_f), 32'b0010);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)), 0);
        end

        op = OP_MUL; a = 8'h5A; b = 8'hC3; use_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef ALU_MUL_EN
        repeat (3) begin @(posedge clk); #1; end
`endif
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", 32'(in_ready), 32'd1);
        acc = 8'h00;
        @(posedge clk); #1;
        check("midrst_no_stale", 32'(out_valid), 32'd0);
        run_op(OP_ADD, 8'h77, 8'h3C, 1'b1, 1'b0, 0, 0);
        check("midrst_acc_zero", 32'(last_y), 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
